enq_arbiter: RTL and testbench



---
 rtl/enq_arbiter.sv | 161 ++++++++++++++++
 tb/tb_enq_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enq_arbiter.sv
// Weighted round-robin merge of two enq producers onto one enq consumer.
// Each producer is decoupled by a small FIFO; a burst counter bounds how long one source holds the output.

module enq_arbiter_fifo #(
   parameter int WIDTH = 128,
   parameter int DEPTH = 2
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic             rdy,
   output logic             not_empty,
   output logic [WIDTH-1:0] head
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   // Ready depends on the registered count only, so a same-cycle pop never frees a slot.
   assign rdy       = count < CW'(DEPTH);
   assign not_empty = count != '0;
   assign head      = mem[rd_ptr];
   assign do_push   = push & rdy;
   assign do_pop    = pop & not_empty;

   // NOTE: the storage array has no reset; entries are only visible through count, which is reset.
   always_ff @(posedge CLK) begin
      if (!RST && do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (RST) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

module enq_arbiter #(
   parameter int WIDTH    = 128,
   parameter int DEPTH    = 2,
   parameter int WEIGHT_A = 2,
   parameter int WEIGHT_B = 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             a_enq__ENA,
   input  logic [WIDTH-1:0] a_enq_v,
   output logic             a_enq__RDY,
   input  logic             b_enq__ENA,
   input  logic [WIDTH-1:0] b_enq_v,
   output logic             b_enq__RDY,
   output logic             out_enq__ENA,
   output logic [WIDTH-1:0] out_enq_v,
   input  logic             out_enq__RDY
);
   localparam int WMAX = (WEIGHT_A > WEIGHT_B) ? WEIGHT_A : WEIGHT_B;
   localparam int BW   = $clog2(WMAX + 1);
   localparam logic [BW-1:0] WA = BW'(WEIGHT_A);
   localparam logic [BW-1:0] WB = BW'(WEIGHT_B);

   typedef enum logic {
      SRC_A = 1'b0,
      SRC_B = 1'b1
   } src_e;

   src_e             cur;
   logic [BW-1:0]    burst;

   logic             a_ne;
   logic             b_ne;
   logic [WIDTH-1:0] a_head;
   logic [WIDTH-1:0] b_head;
   logic             hc;
   logic             ho;
   logic [BW-1:0]    w;
   logic             sel_valid;
   src_e             sel_src;
   logic             fire;
   logic             pop_a;
   logic             pop_b;

   enq_arbiter_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
      .CLK       (CLK),
      .RST       (RST),
      .push      (a_enq__ENA),
      .din       (a_enq_v),
      .pop       (pop_a),
      .rdy       (a_enq__RDY),
      .not_empty (a_ne),
      .head      (a_head)
   );

   enq_arbiter_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
      .CLK       (CLK),
      .RST       (RST),
      .push      (b_enq__ENA),
      .din       (b_enq_v),
      .pop       (pop_b),
      .rdy       (b_enq__RDY),
      .not_empty (b_ne),
      .head      (b_head)
   );

   // Stay on cur until its weight is spent, unless the other source has nothing to send.
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      hc        = (cur == SRC_A) ? a_ne : b_ne;
      ho        = (cur == SRC_A) ? b_ne : a_ne;
      w         = (cur == SRC_A) ? WA : WB;
      sel_valid = 1'b0;
      sel_src   = cur;
      if (hc && ((burst < w) || !ho)) begin
         sel_valid = 1'b1;
         sel_src   = cur;
      end else if (ho) begin
         sel_valid = 1'b1;
         sel_src   = (cur == SRC_A) ? SRC_B : SRC_A;
      end
   end

   assign fire         = sel_valid & out_enq__RDY;
   assign pop_a        = fire & (sel_src == SRC_A);
   assign pop_b        = fire & (sel_src == SRC_B);
   assign out_enq__ENA = fire;
   assign out_enq_v    = !sel_valid ? '0 : ((sel_src == SRC_A) ? a_head : b_head);

   always_ff @(posedge CLK) begin
      if (RST) begin
         cur   <= SRC_A;
         burst <= '0;
      end else if (fire) begin
         if (sel_src == cur) begin
            burst <= (burst < w) ? burst + BW'(1) : w;
         end else begin
            cur   <= sel_src;
            burst <= BW'(1);
         end
      end
   end
endmodule

// File: tb/tb_enq_arbiter.sv
// Self-checking bench for enq_arbiter: directed scenarios plus random traffic,
// all compared against a queue-based model of the weighted round-robin rules.

module tb_enq_arbiter;
   localparam int WIDTH    = 128;
   localparam int DEPTH    = 2;
   localparam int WEIGHT_A = 2;
   localparam int WEIGHT_B = 1;

   logic             CLK = 1'b0;
   logic             RST;
   logic             a_ena;
   logic [WIDTH-1:0] a_v;
   logic             a_rdy;
   logic             b_ena;
   logic [WIDTH-1:0] b_v;
   logic             b_rdy;
   logic             out_ena;
   logic [WIDTH-1:0] out_v;
   logic             out_rdy;

   int checks   = 0;
   int failures = 0;

   // model state: queues per source, last granted source and length of its unbroken run
   logic [WIDTH-1:0] qa[$];
   logic [WIDTH-1:0] qb[$];
   int               m_last;
   int               m_run;

   // expectations for the cycle currently being driven
   int               exp_sel;
   logic             exp_ena;
   logic [WIDTH-1:0] exp_v;
   logic             exp_ra;
   logic             exp_rb;

   enq_arbiter #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .WEIGHT_A(WEIGHT_A), .WEIGHT_B(WEIGHT_B)
   ) dut (
      .CLK          (CLK),
      .RST          (RST),
      .a_enq__ENA   (a_ena),
      .a_enq_v      (a_v),
      .a_enq__RDY   (a_rdy),
      .b_enq__ENA   (b_ena),
      .b_enq_v      (b_v),
      .b_enq__RDY   (b_rdy),
      .out_enq__ENA (out_ena),
      .out_enq_v    (out_v),
      .out_enq__RDY (out_rdy)
   );

   always #5 CLK = ~CLK;

   function automatic int qsize(input int src);
      return (src == 0) ? qa.size() : qb.size();
   endfunction

   // -1 = nothing to send, 0 = A, 1 = B
   function automatic int model_pick();
      int cur_n  = qsize(m_last);
      int oth_n  = qsize(1 - m_last);
      int weight = (m_last == 0) ? WEIGHT_A : WEIGHT_B;
      if (cur_n > 0 && (m_run < weight || oth_n == 0)) return m_last;
      if (oth_n > 0) return 1 - m_last;
      return -1;
   endfunction

   function automatic bit m_ra();
      return qa.size() < DEPTH;
   endfunction

   function automatic bit m_rb();
      return qb.size() < DEPTH;
   endfunction

   function automatic logic [WIDTH-1:0] rand_word();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic drive(input bit r, input bit pa, input logic [WIDTH-1:0] va,
                        input bit pb, input logic [WIDTH-1:0] vb, input bit ordy);
      @(negedge CLK);
      RST     = r;
      a_ena   = pa;
      a_v     = va;
      b_ena   = pb;
      b_v     = vb;
      out_rdy = ordy;
      #1;
      exp_sel = model_pick();
      exp_ena = (exp_sel >= 0) && ordy;
      exp_v   = (exp_sel == 0) ? qa[0] : (exp_sel == 1) ? qb[0] : '0;
      exp_ra  = m_ra();
      exp_rb  = m_rb();
   endtask

   task automatic tick();
      @(posedge CLK);
      if (RST) begin
         qa.delete();
         qb.delete();
         m_last = 0;
         m_run  = 0;
      end else begin
         if (exp_ena) begin
            if (exp_sel == 0) void'(qa.pop_front());
            else              void'(qb.pop_front());
            if (exp_sel == m_last) m_run++;
            else begin
               m_last = exp_sel;
               m_run  = 1;
            end
         end
         if (a_ena && exp_ra) qa.push_back(a_v);
         if (b_ena && exp_rb) qb.push_back(b_v);
      end
   endtask

   task automatic do_reset();
      drive(1, 0, '0, 0, '0, 0);
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      do_reset();
      drive(0, 0, '0, 0, '0, 1);
      checks++;
      if ({out_ena, out_v, a_rdy, b_rdy} !== {1'b0, {WIDTH{1'b0}}, 1'b1, 1'b1}) begin
         failures++;
         $display("FAIL reset_outputs: got ena=%0b v=%h ra=%0b rb=%0b, want ena=0 v=0 ra=1 rb=1",
                  out_ena, out_v, a_rdy, b_rdy);
      end
      tick();
      drive(0, 1, WIDTH'(128'h11), 0, '0, 1);
      checks++;
      if ({out_ena, a_rdy, b_rdy} !== 3'b011) begin
         failures++;
         $display("FAIL single_push_cycle: got ena=%0b ra=%0b rb=%0b, want ena=0 ra=1 rb=1",
                  out_ena, a_rdy, b_rdy);
      end
      tick();
      drive(0, 0, '0, 0, '0, 1);
      checks++;
      if ({out_ena, out_v, a_rdy, b_rdy} !== {1'b1, WIDTH'(128'h11), 1'b1, 1'b1}) begin
         failures++;
         $display("FAIL single_word_out: got ena=%0b v=%h ra=%0b rb=%0b, want ena=1 v=11 ra=1 rb=1",
                  out_ena, out_v, a_rdy, b_rdy);
      end
      tick();
   endtask

   task automatic test_saturated();
      logic [WIDTH-1:0] got[$];
      logic [WIDTH-1:0] want;
      int na = 0;
      int nb = 0;
      do_reset();
      for (int c = 0; c < 13; c++) begin
         bit pa = m_ra();
         bit pb = m_rb();
         drive(0, pa, WIDTH'(8'hA0 + na), pb, WIDTH'(8'hB0 + nb), 1);
         if (pa) na++;
         if (pb) nb++;
         checks++;
         if ({out_ena, out_v, a_rdy, b_rdy} !== {exp_ena, exp_v, exp_ra, exp_rb}) begin
            failures++;
            $display("FAIL saturated_cycle%0d: got ena=%0b v=%h ra=%0b rb=%0b, want ena=%0b v=%h ra=%0b rb=%0b",
                     c, out_ena, out_v, a_rdy, b_rdy, exp_ena, exp_v, exp_ra, exp_rb);
         end
         if (out_ena) got.push_back(out_v);
         tick();
      end
      checks++;
      if (got.size() != 12) begin
         failures++;
         $display("FAIL saturated_no_idle: got %0d grants, want 12", got.size());
      end
      for (int k = 0; k < got.size() && k < 12; k++) begin
         want = (k % 3 == 2) ? WIDTH'(8'hB0 + k / 3) : WIDTH'(8'hA0 + 2 * (k / 3) + k % 3);
         checks++;
         if (got[k] !== want) begin
            failures++;
            $display("FAIL saturated_pattern%0d: got %h, want %h", k, got[k], want);
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      drive(0, 1, WIDTH'(128'hC0), 0, '0, 0);
      tick();
      drive(0, 1, WIDTH'(128'hC1), 0, '0, 0);
      tick();
      drive(0, 0, '0, 0, '0, 0);
      checks++;
      if ({a_rdy, out_ena} !== 2'b00) begin
         failures++;
         $display("FAIL bp_full: got ra=%0b ena=%0b, want ra=0 ena=0", a_rdy, out_ena);
      end
      tick();
      drive(0, 0, '0, 0, '0, 1);
      checks++;
      if ({out_ena, out_v, a_rdy} !== {1'b1, WIDTH'(128'hC0), 1'b0}) begin
         failures++;
         $display("FAIL bp_release0: got ena=%0b v=%h ra=%0b, want ena=1 v=c0 ra=0",
                  out_ena, out_v, a_rdy);
      end
      tick();
      drive(0, 1, WIDTH'(128'hC2), 0, '0, 1);
      checks++;
      if ({out_ena, out_v, a_rdy} !== {1'b1, WIDTH'(128'hC1), 1'b1}) begin
         failures++;
         $display("FAIL bp_release1: got ena=%0b v=%h ra=%0b, want ena=1 v=c1 ra=1",
                  out_ena, out_v, a_rdy);
      end
      tick();
      drive(0, 0, '0, 0, '0, 1);
      checks++;
      if ({out_ena, out_v, a_rdy} !== {1'b1, WIDTH'(128'hC2), 1'b1}) begin
         failures++;
         $display("FAIL bp_held_word: got ena=%0b v=%h ra=%0b, want ena=1 v=c2 ra=1",
                  out_ena, out_v, a_rdy);
      end
      tick();
   endtask

   task automatic test_lone_source();
      logic [WIDTH-1:0] want[7];
      bit               want_ena[7];
      want_ena = '{0, 1, 1, 1, 1, 1, 1};
      want     = '{'0, WIDTH'(128'hD0), WIDTH'(128'hD1), WIDTH'(128'hD2), WIDTH'(128'hD3),
                   WIDTH'(128'hE0), WIDTH'(128'hD4)};
      do_reset();
      for (int c = 0; c < 7; c++) begin
         drive(0, c == 4, WIDTH'(128'hE0), c < 5, WIDTH'(8'hD0 + c), 1);
         checks++;
         if (out_ena !== want_ena[c] || (want_ena[c] && out_v !== want[c])) begin
            failures++;
            $display("FAIL lone_cycle%0d: got ena=%0b v=%h, want ena=%0b v=%h",
                     c, out_ena, out_v, want_ena[c], want[c]);
         end
         checks++;
         if ({out_ena, out_v, b_rdy} !== {exp_ena, exp_v, exp_rb}) begin
            failures++;
            $display("FAIL lone_model%0d: got ena=%0b v=%h rb=%0b, want ena=%0b v=%h rb=%0b",
                     c, out_ena, out_v, b_rdy, exp_ena, exp_v, exp_rb);
         end
         tick();
      end
   endtask

   task automatic test_push_pop_one_entry();
      logic [WIDTH-1:0] sent[$];
      logic [WIDTH-1:0] w;
      do_reset();
      for (int c = 0; c < 5; c++) begin
         w = rand_word();
         drive(0, c < 4, w, 0, '0, 1);
         checks++;
         if (a_rdy !== 1'b1 || out_ena !== (c > 0) || (c > 0 && out_v !== sent[0])) begin
            failures++;
            $display("FAIL pushpop_cycle%0d: got ra=%0b ena=%0b v=%h, want ra=1 ena=%0b v=%h",
                     c, a_rdy, out_ena, out_v, c > 0, (c > 0) ? sent[0] : '0);
         end
         if (c > 0) void'(sent.pop_front());
         if (c < 4) sent.push_back(w);
         tick();
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      for (int c = 0; c < 2; c++) begin
         drive(0, 1, WIDTH'(8'h50 + c), 1, WIDTH'(8'h60 + c), 0);
         tick();
      end
      drive(1, 0, '0, 0, '0, 1);
      tick();
      drive(0, 0, '0, 1, WIDTH'(128'hBEEF), 1);
      checks++;
      if ({out_ena, a_rdy, b_rdy} !== 3'b011) begin
         failures++;
         $display("FAIL midreset_after: got ena=%0b ra=%0b rb=%0b, want ena=0 ra=1 rb=1",
                  out_ena, a_rdy, b_rdy);
      end
      tick();
      drive(0, 0, '0, 0, '0, 1);
      checks++;
      if ({out_ena, out_v} !== {1'b1, WIDTH'(128'hBEEF)}) begin
         failures++;
         $display("FAIL midreset_fresh: got ena=%0b v=%h, want ena=1 v=beef", out_ena, out_v);
      end
      tick();
      drive(0, 0, '0, 0, '0, 1);
      checks++;
      if ({out_ena, out_v} !== {1'b0, {WIDTH{1'b0}}}) begin
         failures++;
         $display("FAIL midreset_no_stale: got ena=%0b v=%h, want ena=0 v=0", out_ena, out_v);
      end
      tick();
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         bit pa   = m_ra() && ($urandom_range(0, 2) != 0);
         bit pb   = m_rb() && ($urandom_range(0, 1) != 0);
         bit ordy = $urandom_range(0, 3) != 0;
         drive(0, pa, rand_word(), pb, rand_word(), ordy);
         checks++;
         if ({out_ena, out_v, a_rdy, b_rdy} !== {exp_ena, exp_v, exp_ra, exp_rb}) begin
            failures++;
            $display("FAIL random_cycle%0d: got ena=%0b v=%h ra=%0b rb=%0b, want ena=%0b v=%h ra=%0b rb=%0b",
                     c, out_ena, out_v, a_rdy, b_rdy, exp_ena, exp_v, exp_ra, exp_rb);
         end
         tick();
      end
   endtask

   initial begin
      RST     = 1'b1;
      a_ena   = 1'b0;
      a_v     = '0;
      b_ena   = 1'b0;
      b_v     = '0;
      out_rdy = 1'b0;
      m_last  = 0;
      m_run   = 0;
      test_reset();
      test_saturated();
      test_backpressure();
      test_lone_source();
      test_push_pop_one_entry();
      test_mid_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
